// File: rtl/i2c_reg_access.sv
// i2c_reg_access: turns one register read/write command into the byte-level
// transfer_start / transfer_continue / mode / data_tx sequence expected by the
// i2c master, and returns one response (status + read data) per command.
module i2c_reg_access #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       m_mode,
  output logic       m_transfer_start,
  output logic       m_transfer_continue,
  output logic [7:0] m_data_tx,
  input  logic       m_transfer_ready,
  input  logic       m_transaction_complete,
  input  logic       m_ack,
  input  logic [7:0] m_data_rx,
  input  logic       m_data_rx_enable,
  input  logic       m_arbitration_err,
  input  logic       m_start_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ADDR_NAK = 2'd1;
  localparam logic [1:0] ST_DATA_NAK = 2'd2;
  localparam logic [1:0] ST_BUS_ERR  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_WDATA, S_RADDR, S_RDATA, S_STOP_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             read_q, read_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             mode_q, mode_d;
  logic             start_q, start_d;
  logic             cont_q, cont_d;
  logic [7:0]       tx_q, tx_d;

  logic bus_err;
  logic master_pulse;

  assign bus_err      = m_arbitration_err | m_start_err;
  assign master_pulse = m_transaction_complete | m_data_rx_enable | bus_err;

  // Next-state and next-output computation for the command sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_d       = read_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    mode_d       = mode_q;
    start_d      = start_q;
    cont_d       = cont_q;
    tx_d         = tx_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          read_d       = cmd_read;
          dev_d        = cmd_dev_addr;
          reg_d        = cmd_reg_addr;
          wdata_d      = cmd_wdata;
          rsp_rdata_d  = 8'h00;
          rsp_status_d = ST_OK;
          cmd_ready_d  = 1'b0;
          start_d      = 1'b1;
          mode_d       = 1'b0;
          cont_d       = 1'b1;
          tx_d         = {cmd_dev_addr, 1'b0};
          state_d      = S_START;
        end
      end
      S_START: begin
        if (!m_transfer_ready) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (m_transaction_complete) begin
          if (m_ack) begin
            rsp_status_d = ST_ADDR_NAK;
            start_d = 1'b0; cont_d = 1'b0; mode_d = 1'b0;
            state_d = S_STOP_WAIT;
          end else begin
            tx_d    = reg_q;
            cont_d  = !read_q;
            start_d = read_q;   // read asks for a repeated START after REG
            state_d = S_REG;
          end
        end
      end
      S_REG: begin
        if (m_transaction_complete) begin
          if (m_ack) begin
            rsp_status_d = ST_DATA_NAK;
            start_d = 1'b0; cont_d = 1'b0; mode_d = 1'b0;
            state_d = S_STOP_WAIT;
          end else if (read_q) begin
            tx_d    = {dev_q, 1'b1};
            cont_d  = 1'b1;
            start_d = 1'b1;
            state_d = S_RADDR;
          end else begin
            tx_d    = wdata_q;
            cont_d  = 1'b0;
            start_d = 1'b0;
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (m_transaction_complete) begin
          if (m_ack) begin
            rsp_status_d = ST_DATA_NAK;
            mode_d = 1'b0;
          end
          start_d = 1'b0;
          cont_d  = 1'b0;
          state_d = S_STOP_WAIT;
        end
      end
      S_RADDR: begin
        if (m_transaction_complete) begin
          if (m_ack) begin
            rsp_status_d = ST_ADDR_NAK;
            start_d = 1'b0; cont_d = 1'b0; mode_d = 1'b0;
            state_d = S_STOP_WAIT;
          end else begin
            mode_d  = 1'b1;
            cont_d  = 1'b0;
            start_d = 1'b0;
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        // The master NACKs the single read byte itself, so m_ack is not an error here.
        if (m_data_rx_enable) rsp_rdata_d = m_data_rx;
        if (m_transaction_complete) begin
          start_d = 1'b0;
          cont_d  = 1'b0;
          state_d = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (m_transfer_ready) begin
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus errors abort the command; an earlier error status is kept.
    if (bus_err && state_q != S_IDLE && state_q != S_DONE) begin
      if (rsp_status_d == ST_OK) rsp_status_d = ST_BUS_ERR;
      start_d = 1'b0; cont_d = 1'b0; mode_d = 1'b0;
      if (state_q != S_STOP_WAIT) state_d = S_STOP_WAIT;
    end

    // Watchdog between master events; expiry skips the wait for transfer_ready.
    if (state_q == S_IDLE || state_q == S_DONE) begin
      cnt_d = '0;
    end else if (state_d != state_q || master_pulse) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      if (rsp_status_d == ST_OK) rsp_status_d = ST_BUS_ERR;
      start_d = 1'b0; cont_d = 1'b0; mode_d = 1'b0;
      rsp_valid_d = 1'b1;
      state_d     = S_DONE;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, command latches and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      dev_q        <= 7'h00;
      reg_q        <= 8'h00;
      wdata_q      <= 8'h00;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      rsp_status_q <= ST_OK;
      mode_q       <= 1'b0;
      start_q      <= 1'b0;
      cont_q       <= 1'b0;
      tx_q         <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_q       <= read_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      mode_q       <= mode_d;
      start_q      <= start_d;
      cont_q       <= cont_d;
      tx_q         <= tx_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_status          = rsp_status_q;
  assign m_mode              = mode_q;
  assign m_transfer_start    = start_q;
  assign m_transfer_continue = cont_q;
  assign m_data_tx           = tx_q;

endmodule
